// File: rtl/lcd_param_pkg.sv
// Shared definitions for the parametrised LCD view controller.
// Command codes, view mode and controller state encodings.
package lcd_param_pkg;

    localparam logic [3:0] CMD_LOAD    = 4'd0;
    localparam logic [3:0] CMD_ZOOMIN  = 4'd1;
    localparam logic [3:0] CMD_ZOOMFIT = 4'd2;
    localparam logic [3:0] CMD_RIGHT   = 4'd3;
    localparam logic [3:0] CMD_LEFT    = 4'd4;
    localparam logic [3:0] CMD_UP      = 4'd5;
    localparam logic [3:0] CMD_DOWN    = 4'd6;
    localparam logic [3:0] CMD_REFRESH = 4'd7;
    localparam logic [3:0] CMD_MIRH    = 4'd8;
    localparam logic [3:0] CMD_MIRV    = 4'd9;

    typedef enum logic {
        FIT  = 1'b0,
        ZOOM = 1'b1
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PREP,
        STREAM,
        DONE
    } state_e;

endpackage

// File: rtl/lcd_frame_mem.sv
// Frame store: DEPTH words of DW bits, one synchronous write port and
// one combinational read port. Ports: clk, we_i/waddr_i/wdata_i, raddr_i/rdata_o.
module lcd_frame_mem #(
    parameter int DW    = 8,
    parameter int DEPTH = 108,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/lcd_ctrl_param.sv
// LCD view controller: loads an IMG_W x IMG_H frame, streams a WIN x WIN
// fit/zoom view. Ports: clk, reset (async low), cmd/cmd_valid, datain,
// dataout/output_valid, busy.
module lcd_ctrl_param
    import lcd_param_pkg::*;
#(
    parameter int IMG_W = 12,
    parameter int IMG_H = 9,
    parameter int WIN   = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] datain,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int MW   = $clog2(NPIX) + 1;
    localparam int MAW  = $clog2(NPIX);
    localparam int XW   = $clog2(IMG_W) + 1;
    localparam int YW   = $clog2(IMG_H) + 1;
    localparam int CW   = $clog2(WIN) + 1;
    localparam int SX   = IMG_W / WIN;
    localparam int SY   = IMG_H / WIN;

    localparam logic [XW-1:0] X0   = XW'((IMG_W + 1) / 2);
    localparam logic [YW-1:0] Y0   = YW'((IMG_H + 1) / 2);
    localparam logic [XW-1:0] XMIN = XW'(WIN / 2);
    localparam logic [XW-1:0] XMAX = XW'(IMG_W - WIN / 2);
    localparam logic [YW-1:0] YMIN = YW'(WIN / 2);
    localparam logic [YW-1:0] YMAX = YW'(IMG_H - WIN / 2);
    localparam logic [MW-1:0] LAST = MW'(NPIX - 1);
    localparam logic [CW-1:0] WEND = CW'(WIN - 1);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [MW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          mh_q, mh_d;
    logic          mv_q, mv_d;
    logic          ov_q, ov_d;
    logic [DW-1:0] dout_q, dout_d;

    logic          we;
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic [MAW-1:0] raddr;
    logic [DW-1:0] rdata;

    lcd_frame_mem #(
        .DW    (DW),
        .DEPTH (NPIX),
        .AW    (MAW)
    ) u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (cnt_q[MAW-1:0]),
        .wdata_i (datain),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // Display coordinate -> stored coordinate; mirroring is applied last
    // so the origin stays in display space.
    always_comb begin
        col = '0;
        row = '0;
        if (mode_q == ZOOM) begin
            col = x_q - XW'(WIN / 2) + XW'(c_q);
            row = y_q - YW'(WIN / 2) + YW'(r_q);
        end else begin
            col = XW'(c_q) * XW'(SX) + XW'(SX / 2);
            row = YW'(r_q) * YW'(SY) + YW'(SY / 2);
        end
        if (mh_q) col = XW'(IMG_W - 1) - col;
        if (mv_q) row = YW'(IMG_H - 1) - row;
        raddr = MAW'(MW'(row) * MW'(IMG_W) + MW'(col));
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        c_d     = c_q;
        x_d     = x_q;
        y_d     = y_q;
        mh_d    = mh_q;
        mv_d    = mv_q;
        ov_d    = 1'b0;
        dout_d  = dout_q;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = PREP;
                    case (cmd)
                        CMD_LOAD: begin
                            state_d = LOAD;
                            cnt_d   = '0;
                        end
                        CMD_ZOOMIN: mode_d = ZOOM;
                        CMD_ZOOMFIT: begin
                            mode_d = FIT;
                            x_d    = X0;
                            y_d    = Y0;
                        end
                        CMD_RIGHT: begin
                            if (mode_q == ZOOM && x_q < XMAX)
                                x_d = x_q + XW'(1);
                        end
                        CMD_LEFT: begin
                            if (mode_q == ZOOM && x_q > XMIN)
                                x_d = x_q - XW'(1);
                        end
                        CMD_UP: begin
                            if (mode_q == ZOOM && y_q > YMIN)
                                y_d = y_q - YW'(1);
                        end
                        CMD_DOWN: begin
                            if (mode_q == ZOOM && y_q < YMAX)
                                y_d = y_q + YW'(1);
                        end
                        CMD_REFRESH: ;
                        CMD_MIRH: mh_d = ~mh_q;
                        CMD_MIRV: mv_d = ~mv_q;
                        // Illegal code: single busy cycle, nothing else.
                        default: state_d = DONE;
                    endcase
                end
            end
            LOAD: begin
                we    = 1'b1;
                cnt_d = cnt_q + MW'(1);
                if (cnt_q == LAST) begin
                    state_d = PREP;
                    mode_d  = FIT;
                    x_d     = X0;
                    y_d     = Y0;
                    mh_d    = 1'b0;
                    mv_d    = 1'b0;
                end
            end
            PREP: begin
                r_d     = '0;
                c_d     = '0;
                state_d = STREAM;
            end
            STREAM: begin
                ov_d   = 1'b1;
                dout_d = rdata;
                if (c_q == WEND) begin
                    c_d = '0;
                    if (r_q == WEND) state_d = DONE;
                    else r_d = r_q + CW'(1);
                end else begin
                    c_d = c_q + CW'(1);
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mode_q  <= FIT;
            cnt_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            x_q     <= X0;
            y_q     <= Y0;
            mh_q    <= 1'b0;
            mv_q    <= 1'b0;
            ov_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            c_q     <= c_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mh_q    <= mh_d;
            mv_q    <= mv_d;
            ov_q    <= ov_d;
            dout_q  <= dout_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign output_valid = ov_q;
    assign dataout      = dout_q;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param: directed plan steps plus random commands,
// checked against a frame/view model built from the display rules.
module tb_lcd_ctrl_param;

    localparam int IMG_W = 12;
    localparam int IMG_H = 9;
    localparam int WIN   = 4;
    localparam int DW    = 8;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NB    = WIN * WIN;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    cmd = '0;
    logic          cmd_valid = 1'b0;
    logic [DW-1:0] datain = '0;
    logic [DW-1:0] dataout;
    logic          output_valid;
    logic          busy;

    always #5 clk = ~clk;

    lcd_ctrl_param #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .WIN   (WIN),
        .DW    (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .datain       (datain),
        .dataout      (dataout),
        .output_valid (output_valid),
        .busy         (busy)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] pix [NPIX];
    logic [DW-1:0] img [NPIX];
    int  got [NB];
    bit  m_zoom, m_mh, m_mv;
    int  m_x, m_y;

    int fit_gold [NB] = '{13, 16, 19, 22, 37, 40, 43, 46,
                          61, 64, 67, 70, 85, 88, 91, 94};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_pix(int r, int c);
        int row, col;
        if (m_zoom) begin
            row = m_y - WIN / 2 + r;
            col = m_x - WIN / 2 + c;
        end else begin
            row = r * (IMG_H / WIN) + (IMG_H / WIN) / 2;
            col = c * (IMG_W / WIN) + (IMG_W / WIN) / 2;
        end
        if (m_mh) col = IMG_W - 1 - col;
        if (m_mv) row = IMG_H - 1 - row;
        return int'(img[row * IMG_W + col]);
    endfunction

    task automatic model_home();
        m_zoom = 1'b0;
        m_mh   = 1'b0;
        m_mv   = 1'b0;
        m_x    = (IMG_W + 1) / 2;
        m_y    = (IMG_H + 1) / 2;
    endtask

    task automatic model_cmd(int c);
        int xmax, ymax;
        xmax = IMG_W - WIN / 2;
        ymax = IMG_H - WIN / 2;
        case (c)
            1: m_zoom = 1'b1;
            2: begin
                m_zoom = 1'b0;
                m_x = (IMG_W + 1) / 2;
                m_y = (IMG_H + 1) / 2;
            end
            3: if (m_zoom && m_x < xmax) m_x++;
            4: if (m_zoom && m_x > WIN / 2) m_x--;
            5: if (m_zoom && m_y > WIN / 2) m_y--;
            6: if (m_zoom && m_y < ymax) m_y++;
            8: m_mh = !m_mh;
            9: m_mv = !m_mv;
            default: ;
        endcase
    endtask

    // Entered at #1 after the reference edge; first beat is two edges later.
    task automatic run_view(string tag, int ign);
        logic [DW-1:0] last;
        @(negedge clk);
        check({tag, ".ov_e1"}, output_valid, 0);
        check({tag, ".busy_e1"}, busy, 1);
        @(negedge clk);
        check({tag, ".ov_e2"}, output_valid, 0);
        last = '0;
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            check($sformatf("%s.ov%0d", tag, i), output_valid, 1);
            check($sformatf("%s.busy%0d", tag, i), busy, 1);
            check($sformatf("%s.pix%0d", tag, i), dataout,
                  exp_pix(i / WIN, i % WIN));
            got[i] = int'(dataout);
            last = dataout;
            if (i == ign) begin
                cmd       = 4'($urandom_range(0, 15));
                cmd_valid = 1'b1;
            end
        end
        @(negedge clk);
        check({tag, ".ov_end"}, output_valid, 0);
        check({tag, ".busy_end"}, busy, 0);
        check({tag, ".hold"}, dataout, last);
    endtask

    task automatic do_cmd(string tag, int c, int ign);
        @(negedge clk);
        check({tag, ".idle"}, busy, 0);
        cmd       = 4'(c);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd       = 4'($urandom_range(0, 15));
        if (c == 0) begin
            for (int k = 0; k < NPIX; k++) begin
                datain = pix[k];
                @(posedge clk);
                #1;
            end
            for (int k = 0; k < NPIX; k++) img[k] = pix[k];
            model_home();
        end else begin
            model_cmd(c);
        end
        if (c >= 10) begin
            @(negedge clk);
            check({tag, ".ill_busy"}, busy, 1);
            check({tag, ".ill_ov"}, output_valid, 0);
            @(negedge clk);
            check({tag, ".ill_busy2"}, busy, 0);
            check({tag, ".ill_ov2"}, output_valid, 0);
        end else begin
            run_view(tag, ign);
        end
    endtask

    task automatic chk_gold(string tag);
        for (int i = 0; i < NB; i++)
            check($sformatf("%s.gold%0d", tag, i), got[i], fit_gold[i]);
    endtask

    task automatic chk_row(string tag, int a, int b, int c, int d);
        check({tag, ".r0"}, got[0], a);
        check({tag, ".r1"}, got[1], b);
        check({tag, ".r2"}, got[2], c);
        check({tag, ".r3"}, got[3], d);
    endtask

    initial begin
        int c, ig;
        model_home();
        for (int k = 0; k < NPIX; k++)
            pix[k] = DW'((k / IMG_W) * 12 + (k % IMG_W));

        #2;
        check("rst.busy", busy, 0);
        check("rst.ov", output_valid, 0);
        check("rst.dout", dataout, 0);
        @(negedge clk);
        reset = 1'b1;

        do_cmd("load", 0, -1);
        chk_gold("load");

        do_cmd("zoomin", 1, -1);
        chk_row("zoomin", 40, 41, 42, 43);
        check("zoomin.row1", got[4], 52);

        for (int i = 0; i < 6; i++)
            do_cmd($sformatf("right%0d", i), 3, -1);
        chk_row("right_clamp", 44, 45, 46, 47);
        for (int i = 0; i < 4; i++)
            do_cmd($sformatf("up%0d", i), 5, -1);
        chk_row("up_clamp", 8, 9, 10, 11);

        do_cmd("zfit", 2, -1);
        do_cmd("zin2", 1, -1);
        do_cmd("mirh", 8, -1);
        chk_row("mirh", 43, 42, 41, 40);
        do_cmd("mirv", 9, -1);
        chk_row("mirv", 67, 66, 65, 64);
        do_cmd("reload", 0, -1);
        chk_gold("reload");

        do_cmd("fitleft", 4, -1);
        chk_gold("fitleft");
        do_cmd("illegal", 12, -1);
        do_cmd("refr_ign", 7, 5);
        chk_gold("refr_ign");

        do_cmd("zin3", 1, -1);
        do_cmd("mirh2", 8, -1);
        @(negedge clk);
        cmd       = 4'd7;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("abort.ov_pre", output_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("abort.ov", output_valid, 0);
        check("abort.busy", busy, 0);
        check("abort.dout", dataout, 0);
        model_home();
        @(negedge clk);
        reset = 1'b1;
        do_cmd("post_rst", 7, -1);
        chk_gold("post_rst");

        for (int k = 0; k < NPIX; k++)
            pix[k] = DW'($urandom_range(0, 255));
        do_cmd("rload", 0, -1);
        for (int i = 0; i < 40; i++) begin
            c = $urandom_range(0, 15);
            if (c == 0 && $urandom_range(0, 3) != 0) c = 7;
            ig = ($urandom_range(0, 1) != 0) ? $urandom_range(0, NB - 2) : -1;
            do_cmd($sformatf("rnd%0d_c%0d", i, c), c, ig);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
